// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the square-root arbiter: controller state encoding,
// default widths/timeout and a one-hot decode helper.
package sqrt_arb_pkg;

   localparam int DEF_DW      = 16;
   localparam int DEF_RW      = 8;
   localparam int DEF_TIMEOUT = 64;
   localparam int MAX_REQ     = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   // One-hot decode of idx into a MAX_REQ-wide vector; out-of-range gives 0.
   function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
      logic [MAX_REQ-1:0] v;
      v = '0;
      if (idx >= 0 && idx < n) v = MAX_REQ'(1) << idx;
      return v;
   endfunction

endpackage

// File: rtl/sqrt_shared_arbiter_rr_pick.sv
// Round-robin winner search (combinational).
//   req_i     : request vector
//   ptr_i     : highest-priority index for this search
//   winner_o  : first set bit found scanning ptr, ptr+1, ... modulo N_REQ
//   any_req_o : at least one request is set
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [IW-1:0]    winner_o,
   output logic             any_req_o
);

   int               idx;
   logic [N_REQ-1:0] req_sh;

   // Scan from the farthest offset down so the nearest offset to ptr is the
   // last (and therefore surviving) assignment.
   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      idx       = 0;
      req_sh    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx    = (int'(ptr_i) + k) % N_REQ;
         req_sh = req_i >> idx;
         if (req_sh[0]) begin
            winner_o  = IW'(idx);
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sqrt_shared_arbiter.sv
// Shares one square-root core among N_REQ requesters with round-robin
// arbitration and a watchdog on the core's completion.
//   clk, rst            : clock, asynchronous active-low reset
//   req_valid/operand   : per-requester request and packed operands
//   req_ready           : one-hot accept pulse (START cycle)
//   rsp_valid/result    : one-hot response pulse, shared result bus
//   rsp_timeout         : response was an aborted operation (result 0)
//   core_start/operand  : start pulse and held operand toward the core
//   core_done/result    : core completion level and result
//   busy, grant_id      : controller not idle, current owner index
module sqrt_shared_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = DEF_DW,
   parameter int RW      = DEF_RW,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int IW      = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_operand,
   output logic [N_REQ-1:0]    req_ready,
   output logic [N_REQ-1:0]    rsp_valid,
   output logic [RW-1:0]       rsp_result,
   output logic                rsp_timeout,
   output logic                core_start,
   output logic [DW-1:0]       core_operand,
   input  logic                core_done,
   input  logic [RW-1:0]       core_result,
   output logic                busy,
   output logic [IW-1:0]       grant_id
);

   localparam int WW = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [DW-1:0]     op_q, op_d;
   logic [WW-1:0]     wd_q, wd_d;
   logic [RW-1:0]     res_q, res_d;
   logic              tmo_q, tmo_d;
   logic [IW-1:0]     win;
   logic              any_req;
   logic [N_REQ*DW-1:0] op_sh;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .winner_o  (win),
      .any_req_o (any_req)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         op_q    <= '0;
         wd_q    <= '0;
         res_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         op_q    <= op_d;
         wd_q    <= wd_d;
         res_q   <= res_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      op_d    = op_q;
      wd_d    = wd_q;
      res_d   = res_q;
      tmo_d   = tmo_q;
      op_sh   = req_operand >> (int'(win) * DW);
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = win;
               op_d    = op_sh[DW-1:0];
               state_d = ST_START;
            end
         end
         ST_START: state_d = ST_SETTLE;
         // core_done may still carry the previous operation's level here.
         ST_SETTLE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // wd_q counts WAIT cycles already elapsed; saturating, never wraps.
            if (wd_q != WW'(TIMEOUT)) wd_d = wd_q + 1'b1;
            if (core_done) begin
               res_d   = core_result;
               tmo_d   = 1'b0;
               state_d = ST_RESP;
            end else if (wd_q >= WW'(TIMEOUT - 1)) begin
               res_d   = '0;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            ptr_d   = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs are decoded from registered state and owner only.
   assign req_ready    = (state_q == ST_START) ? N_REQ'(onehot(int'(grant_q), N_REQ)) : '0;
   assign rsp_valid    = (state_q == ST_RESP)  ? N_REQ'(onehot(int'(grant_q), N_REQ)) : '0;
   assign core_start   = (state_q == ST_START);
   assign busy         = (state_q != ST_IDLE);
   assign core_operand = op_q;
   assign grant_id     = grant_q;
   assign rsp_result   = res_q;
   assign rsp_timeout  = tmo_q;

endmodule

// File: tb/tb_sqrt_shared_arbiter.sv
// Directed bench for sqrt_shared_arbiter with a behavioural core model and
// a response scoreboard.
module tb_sqrt_shared_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N*16-1:0] req_operand = '0;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [7:0]    rsp_result;
   logic          rsp_timeout;
   logic          core_start;
   logic [15:0]   core_operand;
   logic          core_done;
   logic [7:0]    core_result;
   logic          busy;
   logic [1:0]    grant_id;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {int id; int res; int tmo; int cyc;} exp_t;
   exp_t sb[$];

   // Core model: k counts edges since the last start (0 = never started).
   int k = 0;
   int core_delay = 10;
   bit hang = 0;
   bit stale = 0;

   function automatic logic [7:0] isqrt(input logic [15:0] x);
      int r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return 8'(r);
   endfunction

   assign core_done   = (k == 0) ? 1'b0 : hang ? 1'b0 :
                        stale ? (k <= 1 || k >= 5) : (k >= core_delay);
   assign core_result = (stale && k <= 1) ? 8'd99 : isqrt(core_operand);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_start) k <= 1;
      else if (k > 0 && k < 100000) k <= k + 1;
   end

   always #5 clk = ~clk;

   sqrt_shared_arbiter #(.N_REQ(N), .DW(16), .RW(8), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_operand  (req_operand),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_result   (rsp_result),
      .rsp_timeout  (rsp_timeout),
      .core_start   (core_start),
      .core_operand (core_operand),
      .core_done    (core_done),
      .core_result  (core_result),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] v);
      req_operand[i*16 +: 16] = v;
   endtask

   task automatic wait_grant(input int id, input logic [15:0] op, output int c);
      int n;
      @(negedge clk);
      n = 1;
      while (req_ready == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("grant_seen", 32'(req_ready != '0), 1);
      check("req_ready", 32'(req_ready), 32'(4'b0001 << id));
      check("core_start", 32'(core_start), 1);
      check("core_operand", 32'(core_operand), 32'(op));
      check("grant_id", 32'(grant_id), 32'(id));
      c = cyc;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("sb_drained", 32'(sb.size()), 0);
      @(negedge clk);
   endtask

   // Response monitor: every rsp_valid pulse must match the scoreboard head.
   always @(negedge clk) begin
      if (rst && rsp_valid != '0) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            if (e.cyc >= 0) check("rsp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      int c;
      logic [15:0] ops [4];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_core_start", 32'(core_start), 0);
      check("rst_core_operand", 32'(core_operand), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_rsp_result", 32'(rsp_result), 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: single requester, done 10 cycles after start
      core_delay = 10;
      set_op(2, 16'd144);
      req_valid = 4'b0100;
      wait_grant(2, 16'd144, c);
      req_valid[2] = 1'b0;
      sb.push_back('{id: 2, res: 12, tmo: 0, cyc: c + 11});
      drain();

      // 2: all four from reset
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      core_delay = 3;
      ops = '{16'd4, 16'd9, 16'd16, 16'd25};
      for (int i = 0; i < 4; i++) begin
         set_op(i, ops[i]);
         sb.push_back('{id: i, res: i + 2, tmo: 0, cyc: -1});
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_grant(i, ops[i], c);
         req_valid[i] = 1'b0;
      end
      drain();

      // 3: two requesters held continuously
      set_op(0, 16'd36);
      set_op(1, 16'd64);
      sb.push_back('{id: 0, res: 6,  tmo: 0, cyc: -1});
      sb.push_back('{id: 1, res: 8,  tmo: 0, cyc: -1});
      sb.push_back('{id: 0, res: 9,  tmo: 0, cyc: -1});
      sb.push_back('{id: 1, res: 10, tmo: 0, cyc: -1});
      req_valid = 4'b0011;
      wait_grant(0, 16'd36, c);
      set_op(0, 16'd81);
      wait_grant(1, 16'd64, c);
      set_op(1, 16'd100);
      wait_grant(0, 16'd81, c);
      wait_grant(1, 16'd100, c);
      req_valid = '0;
      drain();

      // 4: stale core_done through START/SETTLE
      stale = 1;
      set_op(1, 16'd49);
      sb.push_back('{id: 1, res: 7, tmo: 0, cyc: -1});
      req_valid = 4'b0010;
      wait_grant(1, 16'd49, c);
      req_valid = '0;
      drain();
      stale = 0;

      // 5: core hangs, watchdog aborts after 64 WAIT cycles
      hang = 1;
      set_op(2, 16'd25);
      req_valid = 4'b0100;
      wait_grant(2, 16'd25, c);
      req_valid = '0;
      sb.push_back('{id: 2, res: 0, tmo: 1, cyc: c + 66});
      drain();
      hang = 0;
      set_op(1, 16'd169);
      sb.push_back('{id: 1, res: 13, tmo: 0, cyc: -1});
      req_valid = 4'b0010;
      wait_grant(1, 16'd169, c);
      req_valid = '0;
      drain();

      // 6: asynchronous reset mid-WAIT
      hang = 1;
      set_op(3, 16'd4);
      req_valid = 4'b1000;
      wait_grant(3, 16'd4, c);
      req_valid = '0;
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_core_operand", 32'(core_operand), 0);
      check("arst_grant_id", 32'(grant_id), 0);
      check("arst_rsp_result", 32'(rsp_result), 0);
      check("arst_rsp_timeout", 32'(rsp_timeout), 0);
      check("arst_rsp_valid", 32'(rsp_valid), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      hang = 0;
      repeat (10) @(negedge clk);
      check("arst_no_rsp", 32'(sb.size()), 0);
      ops = '{16'd1, 16'd4, 16'd9, 16'd121};
      for (int i = 0; i < 4; i++) begin
         set_op(i, ops[i]);
         sb.push_back('{id: i, res: int'(isqrt(ops[i])), tmo: 0, cyc: -1});
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_grant(i, ops[i], c);
         req_valid[i] = 1'b0;
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_shared_arbiter.md
Name: sqrt_shared_arbiter

Overview:
- Shares one square-root core among N_REQ requesters using round-robin arbitration.
- Captures the winner's operand, pulses the core start, and waits for core completion, with a watchdog timeout.
- Returns the result to the owning requester only.
- Sits between the requester ports and the core's EN / OP_READY / result pins.

Parameters:
- N_REQ, 4: number of requesters; 2..8, need not be a power of two.
- DW, 16: operand width.
- RW, 8: result width (DW/2).
- TIMEOUT, 64: maximum WAIT cycles before the operation is aborted; at least 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request; held until its req_ready pulse.
- req_operand  in  N_REQ*DW  packed operands; requester i uses bits [i*DW +: DW].
- req_ready  out  N_REQ  one-hot, 1-cycle accept pulse.
- rsp_valid  out  N_REQ  one-hot, 1-cycle response pulse.
- rsp_result  out  RW  shared result bus; valid while any rsp_valid bit is high.
- rsp_timeout  out  1  qualifies rsp_valid: 1 means aborted, rsp_result is 0.
- core_start  out  1  1-cycle pulse to core EN.
- core_operand  out  DW  registered; stable from core_start until RESP.
- core_done  in  1  core ready level (stays high until the next start).
- core_result  in  RW  core result; valid while core_done is high.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(N_REQ)  index of the current owner.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; round-robin pointer ptr goes to 0.
  - All outputs go to 0, including core_operand, grant_id and rsp_result.
  - Reset mid-operation abandons the operation silently; no response is issued.
- States: IDLE, START, SETTLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner w is the first set bit searching ptr, ptr+1, ... wrapping modulo N_REQ.
  - On that edge, register grant_id=w, core_operand=req_operand[w], req_ready=onehot(w); go to START.
  - If no request, stay in IDLE.
- START (1 cycle): req_ready and core_start are high; go to SETTLE.
- SETTLE (1 cycle): core_done is ignored, because a stale level from the previous operation may still be present; clear the watchdog count; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If core_done=1: latch core_result into rsp_result, rsp_timeout=0, go to RESP.
  - Otherwise, on the TIMEOUT-th WAIT cycle: rsp_result=0, rsp_timeout=1, go to RESP.
  - If core_done and the timeout coincide, core_done wins.
- RESP (1 cycle):
  - rsp_valid[grant_id]=1.
  - ptr = (grant_id+1) mod N_REQ.
  - Go to IDLE. rsp_valid is cleared on exit; rsp_result holds its value until the next RESP.
- Outputs are registered or decoded from state only; there is no combinational path from req_* to any output.
- Latency: a request sampled in IDLE at edge 0 gives req_ready/core_start in cycle 1 and WAIT from cycle 3. If core_done is first seen in WAIT cycle m, rsp_valid is high in cycle m+1.
- Minimum turnaround between back-to-back grants is 5 cycles (IDLE included).
- Request rules:
  - A request dropped before req_ready is never served and leaves no state behind.
  - req_valid still high after the req_ready pulse is treated as a new request.
  - req_operand is sampled only on the grant edge.
- Simultaneous requests are resolved only by ptr. From reset with all requests high, the order is 0,1,...,N_REQ-1.
- The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Package sqrt_arb_pkg:
  - state enum typedef (logic [2:0]).
  - Default DW/RW/TIMEOUT constants.
  - Function onehot(idx, n).
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs winner index and any_req. Instantiated once.

Test Plan:
1. Only req_valid[2] high, operand 144; core model raises done 10 cycles after start with result 12.
   -> req_ready=4'b0100 and core_start in cycle 1, core_operand=144.
   -> rsp_valid=4'b0100 with rsp_result=12, rsp_timeout=0, exactly 1 cycle after done is first seen.
2. All four requests high after reset, operands 4, 9, 16, 25.
   -> Grants in order 0,1,2,3; responses 2,3,4,5, each on the owner's rsp_valid bit only.
3. req_valid[0] and [1] held continuously with fresh operands.
   -> Grants alternate 0,1,0,1; no requester is starved.
4. core_done left high from the previous operation through START/SETTLE, then low, then high with result 7.
   -> The stale level is ignored; rsp_result=7.
5. Core never asserts done, TIMEOUT=64.
   -> After exactly 64 WAIT cycles: rsp_valid with rsp_timeout=1 and rsp_result=0.
   -> The following request completes normally.
6. rst pulsed low mid-WAIT.
   -> All outputs 0 immediately (asynchronous), state IDLE, no response issued.
   -> The next simultaneous requests are granted starting from requester 0.
